regfile_wr_arbiter: RTL
=======================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port (i_rd_addr/i_rd_data/i_rd_wren) among NUM_REQ
//  writeback requesters (e.g. ALU writeback, load unit, multi-cycle mul/div) using fair
//  round-robin arbitration. Sits between the writeback sources and regfile; output is registered
//  so the write lands on the regfile one clock after acceptance. Writes to x0 are absorbed.
// PARAMETERS
//  NUM_REQ  2   number of writeback requesters (1..8)
//  ADDR_W   5   register address width
//  DATA_W   32  register data width
// PORTS
//  i_clk        in   1               clock, all state updates on rising edge
//  i_reset      in   1               asynchronous, active-low reset
//  i_hold       in   1               1 = grant nothing this cycle (pipeline freeze)
//  i_req_valid  in   NUM_REQ         per-requester write request
//  i_req_addr   in   NUM_REQ*ADDR_W  dest reg, requester k in [k*ADDR_W +: ADDR_W]
//  i_req_data   in   NUM_REQ*DATA_W  write data, requester k in [k*DATA_W +: DATA_W]
//  o_req_ready  out  NUM_REQ         one-hot grant; transfer = valid & ready
//  o_rd_addr    out  ADDR_W          to regfile i_rd_addr (registered)
//  o_rd_data    out  DATA_W          to regfile i_rd_data (registered)
//  o_rd_wren    out  1               to regfile i_rd_wren (registered)
//  o_grant_id   out  max(1,$clog2(NUM_REQ))  index of last accepted requester (registered)
// BEHAVIOUR
//  - Reset (i_reset=0, async): o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_grant_id=0, rr_ptr=0.
//    Deassertion takes effect at the next rising edge; in-flight write is dropped.
//  - Grant (combinational): if i_hold=0, g = first k with i_req_valid[k]=1, searching
//    rr_ptr, rr_ptr+1, ... wrapping mod NUM_REQ. o_req_ready = onehot(g); all zeros when
//    i_hold=1 or no valid. Ready never asserts for a requester whose valid is 0.
//  - Accept edge (transfer on g): o_rd_addr<=addr[g]; o_rd_data<=data[g];
//    o_rd_wren<=(addr[g]!=0); o_grant_id<=g; rr_ptr<=(g==NUM_REQ-1)?0:g+1.
//  - No-transfer edge: o_rd_wren<=0; o_rd_addr, o_rd_data, o_grant_id, rr_ptr hold.
//  - Latency: accept at edge N -> regfile samples write at edge N+1. Throughput 1 write/cycle.
//  - x0 target: request is accepted (ready=1, pointer advances) but o_rd_wren stays 0.
//  - Same dest from two requesters: serialised in grant order; last granted value persists.
//  - Requesters hold valid/addr/data stable until ready; dropping valid before ready is
//    tolerated (no transfer, no state change).
//  - NUM_REQ=1: rr_ptr constant 0, ready = valid & ~i_hold.
//  - i_hold does not clear o_rd_*: a write accepted on the previous edge still completes
//    (o_rd_wren is low on the cycle after a held cycle).
// TESTING
//  1 Reset: drive i_reset=0 mid-burst -> o_rd_wren=0 immediately, ptr=0; first grant after
//    release goes to req0 when req0,req1 both valid.
//  2 Round-robin: NUM_REQ=2, both valid continuously, addrs 5/6, data A/B -> regfile writes
//    alternate x5=A, x6=B, x5=A ...; each requester ready every other cycle.
//  3 Single requester: only req1 valid, addr 3, data 0x1234 -> ready[1]=1 same cycle, next
//    edge o_rd_wren=1, o_rd_addr=3, o_rd_data=0x1234, o_grant_id=1.
//  4 x0 drop: req0 addr 0, data 0xFFFF_FFFF -> ready[0]=1, o_rd_wren=0 next cycle, ptr->1.
//  5 Hold: both valid, i_hold=1 for 3 cycles -> ready=0, o_rd_wren=0, ptr unchanged; release
//    -> grant resumes at saved ptr.
//  6 Conflict: req0 and req1 both write x7 (0x11, 0x22), ptr=0 -> x7 ends 0x22 after 2 writes.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// The slave side is the arbiter. The master side is the requester group plus the regfile sink.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [ADDR_W-1:0]         o_rd_addr;
    logic [DATA_W-1:0]         o_rd_data;
    logic                      o_rd_wren;
    logic [GID_W-1:0]          o_grant_id;

    modport slave (
        input  i_req_valid, i_req_addr, i_req_data,
        output o_req_ready, o_rd_addr, o_rd_data, o_rd_wren, o_grant_id
    );

    modport master (
        output i_req_valid, i_req_addr, i_req_data,
        input  o_req_ready, o_rd_addr, o_rd_data, o_rd_wren, o_grant_id
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter that shares the single register-file write port among
// NUM_REQ writeback sources. The grant is combinational. The regfile write is
// registered, so it lands one clock after acceptance. Writes that target x0 are
// accepted but never drive the write enable.
module regfile_wr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_hold,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int GID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [GID_W-1:0]   r_rr_ptr;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_rd_wren;
    logic [GID_W-1:0]   r_grant_id;

    logic [GID_W:0]     w_sum;
    logic [GID_W-1:0]   w_cand;
    logic [GID_W-1:0]   w_grant_idx;
    logic               w_grant_vld;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic [GID_W-1:0]   w_ptr_next;

    // Search for the first valid requester, starting at the round-robin pointer and wrapping.
    always_comb begin
        w_sum       = '0;
        w_cand      = '0;
        w_grant_idx = '0;
        w_grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (GID_W+1)'(k);
            if (w_sum >= (GID_W+1)'(NUM_REQ)) begin
                w_cand = GID_W'(w_sum - (GID_W+1)'(NUM_REQ));
            end else begin
                w_cand = GID_W'(w_sum);
            end
            if (!i_hold && !w_grant_vld && bus.i_req_valid[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end else begin
                w_grant_vld = w_grant_vld;
            end
        end
    end

    // Turn the winner into a one-hot ready, select its payload, and compute the next pointer.
    always_comb begin
        w_grant_oh = '0;
        w_sel_addr = bus.i_req_addr[w_grant_idx*ADDR_W +: ADDR_W];
        w_sel_data = bus.i_req_data[w_grant_idx*DATA_W +: DATA_W];
        if (w_grant_vld) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end else begin
            w_grant_oh = '0;
        end
        if (w_grant_idx == GID_W'(NUM_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_grant_idx + GID_W'(1);
        end
    end

    // Register the accepted write toward the regfile and advance the fairness pointer.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rr_ptr   <= '0;
            r_rd_addr  <= '0;
            r_rd_data  <= '0;
            r_rd_wren  <= 1'b0;
            r_grant_id <= '0;
        end else if (w_grant_vld) begin
            r_rd_addr  <= w_sel_addr;
            r_rd_data  <= w_sel_data;
            r_rd_wren  <= (w_sel_addr != '0);
            r_grant_id <= w_grant_idx;
            r_rr_ptr   <= w_ptr_next;
        end else begin
            r_rd_wren  <= 1'b0;
        end
    end

    assign bus.o_req_ready = w_grant_oh;
    assign bus.o_rd_addr   = r_rd_addr;
    assign bus.o_rd_data   = r_rd_data;
    assign bus.o_rd_wren   = r_rd_wren;
    assign bus.o_grant_id  = r_grant_id;
endmodule
